// File: rtl/riscv_muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit.
package riscv_muldiv_pkg;

    localparam logic [2:0] MULDIV_MUL    = 3'd0;
    localparam logic [2:0] MULDIV_MULH   = 3'd1;
    localparam logic [2:0] MULDIV_MULHSU = 3'd2;
    localparam logic [2:0] MULDIV_MULHU  = 3'd3;
    localparam logic [2:0] MULDIV_DIV    = 3'd4;
    localparam logic [2:0] MULDIV_DIVU   = 3'd5;
    localparam logic [2:0] MULDIV_REM    = 3'd6;
    localparam logic [2:0] MULDIV_REMU   = 3'd7;

    localparam int MULDIV_ITERS = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/riscv_muldiv_if.sv
// Execute-stage handshake between the operand muxes/writeback and the mul/div unit.
interface riscv_muldiv_if #(parameter int XLEN = 32);
    logic            start;
    logic            kill;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, kill, funct3, op_a, op_b, input busy, done, result);
    modport slave  (input start, kill, funct3, op_a, op_b, output busy, done, result);
endinterface

// File: rtl/riscv_muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial subtract for divide.
module muldiv_step #(parameter int XLEN = 32) (
    input  logic              is_div,
    input  logic [2*XLEN-1:0] acc_in,
    input  logic [XLEN-1:0]   operand,
    output logic [2*XLEN-1:0] acc_out
);
    logic [XLEN:0]   add_sum;
    logic [XLEN:0]   rem_shift;
    logic [XLEN-1:0] diff;
    logic            fits;

    always_comb begin
        add_sum   = {1'b0, acc_in[2*XLEN-1:XLEN]} + (acc_in[0] ? {1'b0, operand} : '0);
        // Remainder shifted left with the next dividend bit; 33 bits so the compare cannot overflow.
        rem_shift = acc_in[2*XLEN-1:XLEN-1];
        fits      = rem_shift >= {1'b0, operand};
        diff      = rem_shift[XLEN-1:0] - operand;
        acc_out   = {add_sum, acc_in[XLEN-1:1]};
        if (is_div) begin
            if (fits) acc_out = {diff, acc_in[XLEN-2:0], 1'b1};
            else      acc_out = {rem_shift[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide unit; one bit per cycle on operand magnitudes.
// Define RISCV_MULDIV_FAST_MUL_EN for single-cycle multiplies.
module riscv_muldiv
    import riscv_muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    riscv_muldiv_if.slave   mdu
);
    localparam int CNT_W = $clog2(XLEN);

    muldiv_state_t     state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [2*XLEN-1:0] acc, acc_nx, prod;
    logic [XLEN-1:0]   operand_r, result_r;
    logic [2:0]        op_r;
    logic              neg_r;

    logic              accept, last_iter;
    logic              a_sgn, b_sgn, neg_a, neg_b, div_zero, div_ovf, bypass;
    logic [XLEN-1:0]   mag_a, mag_b, bypass_res, quo_rem, fin_res;

`ifdef RISCV_MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a, fast_b, fast_p;
`endif

    always_comb begin
        a_sgn    = !(mdu.funct3 inside {MULDIV_MULHU, MULDIV_DIVU, MULDIV_REMU});
        b_sgn    = mdu.funct3 inside {MULDIV_MUL, MULDIV_MULH, MULDIV_DIV, MULDIV_REM};
        neg_a    = a_sgn & mdu.op_a[XLEN-1];
        neg_b    = b_sgn & mdu.op_b[XLEN-1];
        mag_a    = neg_a ? -mdu.op_a : mdu.op_a;
        mag_b    = neg_b ? -mdu.op_b : mdu.op_b;
        div_zero = mdu.funct3[2] && (mdu.op_b == '0);
        div_ovf  = (mdu.funct3 inside {MULDIV_DIV, MULDIV_REM})
                   && (mdu.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (mdu.op_b == '1);
        bypass     = div_zero | div_ovf;
        bypass_res = '0;
        if (div_zero)     bypass_res = mdu.funct3[1] ? mdu.op_a : '1;
        else if (div_ovf) bypass_res = mdu.funct3[1] ? '0 : mdu.op_a;
`ifdef RISCV_MULDIV_FAST_MUL_EN
        // Sign-extending to 2*XLEN keeps the low 2*XLEN product bits exact for every signedness mix.
        fast_a = {{XLEN{neg_a}}, mdu.op_a};
        fast_b = {{XLEN{b_sgn & mdu.op_b[XLEN-1]}}, mdu.op_b};
        fast_p = fast_a * fast_b;
        if (!mdu.funct3[2]) begin
            bypass     = 1'b1;
            bypass_res = (mdu.funct3 == MULDIV_MUL) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
        end
`endif
    end

    assign accept    = ((state == ST_IDLE) || (state == ST_DONE)) && mdu.start && !mdu.kill;
    assign last_iter = (state == ST_CALC) && (cnt == CNT_W'(MULDIV_ITERS - 1));

    muldiv_step #(.XLEN(XLEN)) u_step (
        .is_div  (op_r[2]),
        .acc_in  (acc),
        .operand (operand_r),
        .acc_out (acc_nx)
    );

    // Sign correction of the final iteration's output, registered on the CALC->DONE edge.
    always_comb begin
        prod    = neg_r ? -acc_nx : acc_nx;
        quo_rem = op_r[1] ? acc_nx[2*XLEN-1:XLEN] : acc_nx[XLEN-1:0];
        if (op_r[2])                 fin_res = neg_r ? -quo_rem : quo_rem;
        else if (op_r == MULDIV_MUL) fin_res = prod[XLEN-1:0];
        else                         fin_res = prod[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE, ST_DONE: state_nx = accept ? (bypass ? ST_DONE : ST_CALC) : ST_IDLE;
            ST_CALC:          if (last_iter) state_nx = ST_DONE;
            default:          state_nx = ST_IDLE;
        endcase
        if (mdu.kill) state_nx = ST_IDLE;
        mdu.busy = (state == ST_CALC);
        mdu.done = (state == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            acc       <= '0;
            operand_r <= '0;
            op_r      <= '0;
            neg_r     <= 1'b0;
            result_r  <= '0;
        end else if (accept) begin
            op_r      <= mdu.funct3;
            cnt       <= '0;
            acc       <= {{XLEN{1'b0}}, mag_a};
            operand_r <= mag_b;
            neg_r     <= (mdu.funct3[2] & mdu.funct3[1]) ? neg_a : (neg_a ^ neg_b);
            if (bypass) result_r <= bypass_res;
        end else if ((state == ST_CALC) && !mdu.kill) begin
            acc <= acc_nx;
            cnt <= cnt + 1'b1;
            if (last_iter) result_r <= fin_res;
        end
    end

    assign mdu.result = result_r;

endmodule

// File: tb/tb_riscv_muldiv.sv
// Scoreboard bench for riscv_muldiv: latency, results, kill, back-to-back and async reset.
module tb_riscv_muldiv;
    import riscv_muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst;

    riscv_muldiv_if #(.XLEN(32)) bus ();
    riscv_muldiv #(.XLEN(32)) dut (.clk(clk), .rst(rst), .mdu(bus));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct { logic [31:0] res; int due; int lat; } exp_t;
    typedef struct { logic [2:0] f; logic [31:0] a; logic [31:0] b; } op_t;

    exp_t        sb_q[$];
    logic [31:0] last_res = '0;

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 32'd0) return 1;
        if ((f == MULDIV_DIV || f == MULDIV_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef RISCV_MULDIV_FAST_MUL_EN
        if (!f[2]) return 1;
`endif
        return 33;
    endfunction

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        ea, eb, p;
        logic signed [31:0] sa, sb, sq;
        logic [31:0]        r;
        logic               ovf;
        ea  = {{32{a[31] & (f != MULDIV_MULHU)}}, a};
        eb  = {{32{b[31] & (f == MULDIV_MUL || f == MULDIV_MULH)}}, b};
        p   = ea * eb;
        sa  = a;
        sb  = b;
        sq  = '0;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        r   = '0;
        case (f)
            MULDIV_MUL:                              r = p[31:0];
            MULDIV_MULH, MULDIV_MULHSU, MULDIV_MULHU: r = p[63:32];
            MULDIV_DIV: begin
                if (b == 0)   r = 32'hFFFF_FFFF;
                else if (ovf) r = a;
                else begin sq = sa / sb; r = sq; end
            end
            MULDIV_DIVU: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            MULDIV_REM: begin
                if (b == 0)   r = a;
                else if (ovf) r = 32'd0;
                else begin sq = sa % sb; r = sq; end
            end
            default: r = (b == 0) ? a : a % b;
        endcase
        return r;
    endfunction

    task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit track);
        int lat;
        bus.start  = 1'b1;
        bus.funct3 = f;
        bus.op_a   = a;
        bus.op_b   = b;
        lat = exp_lat(f, a, b);
        if (track) sb_q.push_back('{model(f, a, b), cyc + lat, lat});
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.funct3 = 3'($urandom);
        bus.op_a   = $urandom;
        bus.op_b   = $urandom;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.kill = 1'b0; bus.funct3 = '0; bus.op_a = '0; bus.op_b = '0;
        repeat (3) @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done); end
        total++; if (bus.result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=00000000", bus.result); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_arith();
        op_t  ops[22];
        exp_t e;
        int   busy_n;
        bit   got;
        ops[0]  = '{MULDIV_MUL,    32'd7,          32'hFFFF_FFFD};
        ops[1]  = '{MULDIV_MULH,   32'd7,          32'hFFFF_FFFD};
        ops[2]  = '{MULDIV_MULHU,  32'd7,          32'hFFFF_FFFD};
        ops[3]  = '{MULDIV_MULHSU, 32'h8000_0000,  32'hFFFF_FFFF};
        ops[4]  = '{MULDIV_DIV,    32'hFFFF_FFF9,  32'd2};
        ops[5]  = '{MULDIV_REM,    32'hFFFF_FFF9,  32'd2};
        ops[6]  = '{MULDIV_DIVU,   32'd100,        32'd7};
        ops[7]  = '{MULDIV_REMU,   32'd100,        32'd7};
        ops[8]  = '{MULDIV_DIVU,   32'h0000_1234,  32'd0};
        ops[9]  = '{MULDIV_REMU,   32'h0000_1234,  32'd0};
        ops[10] = '{MULDIV_DIV,    32'h8000_0000,  32'hFFFF_FFFF};
        ops[11] = '{MULDIV_REM,    32'h8000_0000,  32'hFFFF_FFFF};
        ops[12] = '{MULDIV_DIV,    32'd7,          32'hFFFF_FFFE};
        ops[13] = '{MULDIV_REM,    32'd7,          32'hFFFF_FFFE};
        for (int i = 14; i < 22; i++)
            ops[i] = '{3'($urandom_range(0, 7)), $urandom, (i % 4 == 0) ? 32'd0 : $urandom};
        for (int i = 0; i < 22; i++) begin
            launch(ops[i].f, ops[i].a, ops[i].b, 1'b1);
            busy_n = 0;
            got    = 1'b0;
            for (int t = 0; t < 40 && !got; t++) begin
                @(negedge clk);
                if (bus.busy) busy_n++;
                if (bus.done) got = 1'b1;
            end
            e = sb_q.pop_front();
            total++;
            if (!got) begin
                bad++;
                $display("FAIL arith[%0d]_timeout f=%0d no done seen, want done at cycle %0d", i, ops[i].f, e.due);
            end else begin
                if (cyc !== e.due) begin bad++; $display("FAIL arith[%0d]_latency got cycle=%0d want=%0d", i, cyc, e.due); end
                total++;
                if (bus.result !== e.res) begin
                    bad++;
                    $display("FAIL arith[%0d]_result f=%0d a=%h b=%h got=%h want=%h", i, ops[i].f, ops[i].a, ops[i].b, bus.result, e.res);
                end
                total++;
                if (busy_n !== e.lat - 1) begin bad++; $display("FAIL arith[%0d]_busy got=%0d cycles want=%0d", i, busy_n, e.lat - 1); end
                last_res = e.res;
                @(negedge clk);
                total++;
                if (bus.done !== 1'b0) begin bad++; $display("FAIL arith[%0d]_done_pulse got=%b want=0", i, bus.done); end
            end
        end
    endtask

    task automatic test_kill();
        int done_n;
        launch(MULDIV_DIV, 32'hFFFF_FC18, 32'd7, 1'b0);
        repeat (9) @(posedge clk);
        #1 bus.kill = 1'b1;
        @(posedge clk); #1;
        bus.kill = 1'b0;
        @(negedge clk);
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL kill_busy got=%b want=0", bus.busy); end
        done_n = 0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (bus.done) done_n++;
        end
        total++; if (done_n !== 0) begin bad++; $display("FAIL kill_no_done got=%0d pulses want=0", done_n); end
        total++; if (bus.result !== last_res) begin bad++; $display("FAIL kill_result got=%h want=%h", bus.result, last_res); end
        bus.start = 1'b1; bus.kill = 1'b1;
        bus.funct3 = MULDIV_DIVU; bus.op_a = 32'd5; bus.op_b = 32'd0;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.kill = 1'b0;
        done_n = 0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            if (bus.done || bus.busy) done_n++;
        end
        total++; if (done_n !== 0) begin bad++; $display("FAIL start_kill_launch got=%0d active cycles want=0", done_n); end
        total++; if (bus.result !== last_res) begin bad++; $display("FAIL start_kill_result got=%h want=%h", bus.result, last_res); end
    endtask

    task automatic test_back_to_back();
        op_t  ops[3];
        exp_t e;
        int   busy_n;
        bit   got;
        ops[0] = '{MULDIV_DIVU,   32'd100,       32'd7};
        ops[1] = '{MULDIV_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        ops[2] = '{MULDIV_MUL,    32'd7,         32'hFFFF_FFFD};
        launch(ops[0].f, ops[0].a, ops[0].b, 1'b1);
        for (int i = 0; i < 3; i++) begin
            busy_n = 0;
            got    = 1'b0;
            for (int t = 0; t < 40 && !got; t++) begin
                @(negedge clk);
                if (bus.busy) busy_n++;
                if (bus.done) got = 1'b1;
                bus.start = (t == 5) && bus.busy;
            end
            bus.start = 1'b0;
            e = sb_q.pop_front();
            total++;
            if (!got) begin
                bad++;
                $display("FAIL b2b[%0d]_timeout no done seen, want done at cycle %0d", i, e.due);
            end else begin
                if (cyc !== e.due) begin bad++; $display("FAIL b2b[%0d]_latency got cycle=%0d want=%0d", i, cyc, e.due); end
                total++;
                if (bus.result !== e.res) begin bad++; $display("FAIL b2b[%0d]_result got=%h want=%h", i, bus.result, e.res); end
                total++;
                if (busy_n !== e.lat - 1) begin bad++; $display("FAIL b2b[%0d]_busy got=%0d cycles want=%0d", i, busy_n, e.lat - 1); end
                last_res = e.res;
                if (i < 2) launch(ops[i+1].f, ops[i+1].a, ops[i+1].b, 1'b1);
            end
        end
        @(negedge clk);
        total++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            bad++; $display("FAIL b2b_idle got done=%b busy=%b want 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_async_reset();
        launch(MULDIV_DIVU, 32'hDEAD_BEEF, 32'd3, 1'b0);
        repeat (6) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL async_rst_busy got=%b want=0", bus.busy); end
        total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL async_rst_done got=%b want=0", bus.done); end
        total++; if (bus.result !== 32'd0) begin bad++; $display("FAIL async_rst_result got=%h want=00000000", bus.result); end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            bad++; $display("FAIL post_rst_idle got busy=%b done=%b want 0 0", bus.busy, bus.done);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached, want test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_arith();
        test_kill();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_muldiv.md
Name: riscv_muldiv

Overview:
Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the ALU operand muxes; it consumes the selected A/B operands in parallel with the ALU. A start pulse launches the operation. The unit holds the pipeline via busy and returns the 32-bit result with a one-cycle done pulse, which the writeback mux consumes. Radix-2 shift-add multiply and restoring divide, one bit per cycle.

Parameters:
XLEN, 32, operand/result width (only 32 supported; iteration counter is $clog2(XLEN) bits)

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  launch request; sampled only when state is IDLE or DONE
kill  input  1  pipeline flush; aborts any in-flight op
funct3  input  3  RV32M op: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
op_a  input  32  rs1 value (forwarded A operand)
op_b  input  32  rs2 value (B mux output, register/forward path)
busy  output  1  high while state is CALC; stall request to hazard unit
done  output  1  one-cycle pulse, high while state is DONE
result  output  32  result; valid when done, held until the next done

Behaviour:
- Reset (async, rst=1): state IDLE, busy=0, done=0, result=0, counter=0, internal accumulators 0.
- States:
  - IDLE -> CALC on start & !kill.
  - CALC: 32 iterations, counter 0..31. After the iteration with counter=31, go to DONE.
  - DONE -> CALC if start & !kill; else -> IDLE.
  - Any state -> IDLE on kill. Kill beats a simultaneous start. Done is never raised for a killed op, and result is not updated.
- Latency: start high in cycle N -> done high in cycle N+33; busy high in cycles N+1..N+32.
- Back-to-back: a start in the DONE cycle is accepted, giving no idle bubble. A start while in CALC is ignored with no error.
- Operand/funct3 capture: latched on the accepting edge. Later changes on op_a, op_b or funct3 have no effect.
- Signed handling: at start, compute magnitudes and sign flags.
  - MUL/MULH: both operands signed.
  - MULHSU: op_a signed, op_b unsigned.
  - DIV/REM: both operands signed.
  - The unsigned core runs on the magnitudes. Sign correction is applied on the CALC->DONE edge.
- Multiply: 64-bit product.
  - MUL returns bits [31:0].
  - MULH/MULHSU/MULHU return bits [63:32] of the correctly signed product.
- Divide: quotient and remainder truncate toward zero; the remainder sign follows the dividend.
- Special cases, detected at start, bypass CALC (IDLE/DONE -> DONE directly; start in N -> done in N+1, busy never high):
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return op_a.
  - Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF): DIV returns 0x80000000; REM returns 0.
- Reset mid-operation: immediate return to IDLE, outputs to their reset values.

Optional Feature:
RISCV_MULDIV_FAST_MUL_EN
- Defined: MUL/MULH/MULHSU/MULHU use a single-cycle 33x33 signed multiply, taking the special-case path (start N -> done N+1, busy never high). Divide is unchanged.
- Undefined: all multiplies use the 32-iteration shift-add path with 33-cycle latency.

Decomposition:
- Shared package riscv_muldiv_pkg:
  - funct3 encodings (MULDIV_MUL..MULDIV_REMU)
  - state encoding (ST_IDLE, ST_CALC, ST_DONE, 2 bits)
  - MULDIV_ITERS=32
- One sub-module, muldiv_step: combinational single-iteration datapath. It performs the conditional add/shift for multiply, or the trial subtract/shift for divide, selected by an is_div input. It is instantiated once in riscv_muldiv; riscv_muldiv keeps the FSM, counter, operand/sign registers and output register.

Test Plan:
- MUL op_a=7, op_b=-3 (0xFFFFFFFD), start in cycle 10 -> busy cycles 11..42, done in cycle 43, result=0xFFFFFFEB; MULH same operands -> 0xFFFFFFFF; MULHU -> 0x00000006.
- DIV op_a=-7, op_b=2 -> result 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIVU op_a=100, op_b=7 -> 14; REMU -> 2; each done at start+33.
- DIVU op_b=0, op_a=0x1234 -> done next cycle, busy never high, result 0xFFFFFFFF; REMU -> 0x1234; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 in 1 cycle.
- kill asserted in the 10th CALC cycle of a DIV -> state IDLE next edge, no done pulse, result retains its previous value; start+kill in the same cycle -> no launch.
- Back-to-back: new start (MULHSU op_a=-1, op_b=0xFFFFFFFF) in the DONE cycle of the previous op -> no idle bubble, result 0xFFFFFFFF; start pulses during CALC are ignored.
- Async rst raised mid-CALC between clock edges -> busy, done and result go to 0 immediately; with RISCV_MULDIV_FAST_MUL_EN defined, MUL 7 * -3 -> done at start+1, result 0xFFFFFFEB.
